bcd_operand_loader: RTL

BCD_OPERAND_LOADER -- requirements
Module: bcd_operand_loader

---
 rtl/bcd_operand_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bcd_operand_loader.sv
// Two-digit BCD operand entry: a debounced KEY1 press captures SW[3:0] as X, then Y plus carry-in.
// Invalid digits (>9) raise a sticky LEDR9 and leave the entry step unchanged.
module bcd_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic [8:0] SW,
    output logic [3:0] op_x,
    output logic [3:0] op_y,
    output logic       op_cin,
    output logic       op_valid,
    output logic       LEDR9,
    output logic [1:0] state
);

    localparam int unsigned CntW = 20;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        StX    = 2'b00,
        StY    = 2'b01,
        StDone = 2'b10
    } state_e;

    logic            key_meta_q, key_sync_q;
    logic [1:0]      sync_vld_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            arm_q, arm_d;
    logic            press_q, press_d;

    state_e          state_q, state_d;
    logic [3:0]      op_x_q, op_x_d, op_y_q, op_y_d;
    logic            op_cin_q, op_cin_d, op_valid_q, op_valid_d, err_q, err_d;
    logic            digit_ok;
    logic            unused_sw;

    assign unused_sw = ^SW[7:4];
    assign digit_ok  = (SW[3:0] <= 4'd9);

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (key_sync_q != deb_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CntMax) begin
                deb_d = key_sync_q;
                cnt_d = '0;
            end
        end
    end

    // Arm only on a released level actually sampled after reset, so a key held
    // through reset release never produces a press.
    always_comb begin
        arm_d   = arm_q;
        press_d = arm_q & deb_q & ~deb_d;
        if (sync_vld_q[1] && deb_q && key_sync_q) arm_d = 1'b1;
        if (press_q) arm_d = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        op_x_d     = op_x_q;
        op_y_d     = op_y_q;
        op_cin_d   = op_cin_q;
        op_valid_d = op_valid_q;
        err_d      = err_q;
        if (press_q) begin
            unique case (state_q)
                StX: begin
                    if (digit_ok) begin
                        op_x_d  = SW[3:0];
                        err_d   = 1'b0;
                        state_d = StY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StY: begin
                    if (digit_ok) begin
                        op_y_d     = SW[3:0];
                        op_cin_d   = SW[8];
                        err_d      = 1'b0;
                        op_valid_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                StDone: begin
                    op_valid_d = 1'b0;
                    state_d    = StX;
                end
                default: state_d = StX;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            sync_vld_q <= 2'b00;
            deb_q      <= 1'b1;
            cnt_q      <= '0;
            arm_q      <= 1'b0;
            press_q    <= 1'b0;
            state_q    <= StX;
            op_x_q     <= 4'd0;
            op_y_q     <= 4'd0;
            op_cin_q   <= 1'b0;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            key_meta_q <= KEY1;
            key_sync_q <= key_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            arm_q      <= arm_d;
            press_q    <= press_d;
            state_q    <= state_d;
            op_x_q     <= op_x_d;
            op_y_q     <= op_y_d;
            op_cin_q   <= op_cin_d;
            op_valid_q <= op_valid_d;
            err_q      <= err_d;
        end
    end

    assign op_x     = op_x_q;
    assign op_y     = op_y_q;
    assign op_cin   = op_cin_q;
    assign op_valid = op_valid_q;
    assign LEDR9    = err_q;
    assign state    = state_q;

endmodule
